byte_serial_comp: RTL and testbench

Byte-serial unsigned magnitude comparator for operands wider than one byte. Two NBYTES-wide operands arrive one byte pair per accepted beat, most-significant byte first. Each beat is folded into a registered EQ/GT cascade state using the same rule as the team's 8-bit cascaded comparator slice (comp_8), which the implementation may instantiate. This block is the sequential front end that feeds that slice and consumes its cascade outputs, and it produces a single registered EQ/GT/LT result per comparison.

---
 rtl/byte_serial_comp_if.sv | 24 ++
 rtl/byte_serial_comp.sv | 92 +++++++++
 tb/tb_byte_serial_comp.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/byte_serial_comp_if.sv
// Handshake and operand bus for the byte-serial magnitude comparator.
// A byte pair moves on a rising clk edge only when in_valid and in_ready are both high.
interface byte_serial_comp_if;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [7:0] B;
  logic       EQ;
  logic       GT;
  logic       LT;
  logic       done;
  logic       busy;

  modport master (
    output start, in_valid, A, B,
    input  in_ready, EQ, GT, LT, done, busy
  );

  modport slave (
    input  start, in_valid, A, B,
    output in_ready, EQ, GT, LT, done, busy
  );
endinterface

// File: rtl/byte_serial_comp.sv
// Byte-serial unsigned comparator: folds NBYTES byte pairs, MSB first, into an
// EQ/GT cascade and publishes one registered EQ/GT/LT result per comparison.
module byte_serial_comp #(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  byte_serial_comp_if.slave    bus,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          eq_r;
  logic          gt_r;
  logic          eq_n;
  logic          gt_n;
  logic          beat;

  // Cascade slice: once a higher byte differs, eq_r is 0 and lower bytes are inert.
  always_comb begin
    eq_n = eq_r & (bus.A == bus.B);
    gt_n = gt_r | (eq_r & (bus.A > bus.B));
  end

  assign beat      = bus.in_valid & bus.in_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      eq_r         <= 1'b1;
      gt_r         <= 1'b0;
      bus.EQ       <= 1'b0;
      bus.GT       <= 1'b0;
      bus.LT       <= 1'b0;
      bus.done     <= 1'b0;
      bus.busy     <= 1'b0;
      bus.in_ready <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state        <= RUN;
            cnt          <= '0;
            eq_r         <= 1'b1;
            gt_r         <= 1'b0;
            bus.in_ready <= 1'b1;
            bus.busy     <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (beat) begin
            eq_r <= eq_n;
            gt_r <= gt_n;
            if (cnt == LAST) begin
              // Final byte goes straight into the result; cnt stays put.
              state        <= DONE;
              bus.EQ       <= eq_n;
              bus.GT       <= gt_n;
              bus.LT       <= ~eq_n & ~gt_n;
              bus.done     <= 1'b1;
              bus.in_ready <= 1'b0;
              bus.busy     <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state        <= IDLE;
          bus.in_ready <= 1'b0;
          bus.busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_serial_comp.sv
// Directed bench for byte_serial_comp (NBYTES=4): a driver issues comparisons and
// queues the expected result and done cycle; a monitor checks each done pulse.
module tb_byte_serial_comp;
  localparam int NBYTES = 4;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;
  int         cyc;
  int         pass_cnt;
  int         total_cnt;

  logic [2:0] exp_q[$];   // {EQ,GT,LT}
  int         cyc_q[$];   // cycle count at which done must be seen

  byte_serial_comp_if bus();

  byte_serial_comp #(.NBYTES(NBYTES)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // driver: one comparison; bubbles[i] inserts an idle cycle before byte i,
  // mid_start pulses start during RUN. Ends right after the last byte is driven,
  // so a following call asserts start in the DONE cycle.
  task automatic run_cmp(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] exp_res, input logic [3:0] bubbles,
                         input bit mid_start);
    int nb;
    nb = 0;
    for (int i = 0; i < NBYTES; i++) nb += int'(bubbles[i]);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_valid = 1'b0;
    exp_q.push_back(exp_res);
    cyc_q.push_back(cyc + NBYTES + 1 + nb);
    for (int i = 0; i < NBYTES; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bubbles[i]) begin
        bus.in_valid = 1'b0;
        bus.A = 8'hA5;
        bus.B = 8'h5A;
        @(negedge clk);
      end
      bus.in_valid = 1'b1;
      bus.A = a[31 - 8*i -: 8];
      bus.B = b[31 - 8*i -: 8];
      if (mid_start && i == 1) bus.start = 1'b1;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        logic [2:0] e;
        int         ec;
        e  = exp_q.pop_front();
        ec = cyc_q.pop_front();
        check("result_eq_gt_lt", int'({bus.EQ, bus.GT, bus.LT}), int'(e));
        check("done_cycle", cyc, ec);
      end
    end
  end

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    reset        = 1'b1;
    bus.start    = 1'b1;
    bus.in_valid = 1'b1;
    bus.A        = 8'h11;
    bus.B        = 8'h22;

    // reset held 2 cycles with start and in_valid asserted
    repeat (2) @(negedge clk);
    check("rst_eq", int'(bus.EQ), 0);
    check("rst_gt", int'(bus.GT), 0);
    check("rst_lt", int'(bus.LT), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_state", int'(dbg_state), 0);

    // in_valid in IDLE is ignored and does not start anything
    reset     = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_state", int'(dbg_state), 0);
    check("idle_in_ready", int'(bus.in_ready), 0);
    check("idle_busy", int'(bus.busy), 0);
    idle_cycles(1);

    // equal operands, continuous
    run_cmp(32'h12345678, 32'h12345678, 3'b100, 4'b0000, 1'b0);
    @(negedge clk);
    check("run_busy_cleared", int'(bus.busy), 0);
    idle_cycles(1);
    // MSB decides, lower bytes favour B
    run_cmp(32'h80000000, 32'h7FFFFFFF, 3'b010, 4'b0000, 1'b0);
    idle_cycles(2);
    // carry boundary
    run_cmp(32'h000000FF, 32'h00000100, 3'b001, 4'b0000, 1'b0);
    idle_cycles(2);
    // two bubbles plus a start pulse during RUN
    run_cmp(32'hDEADBEEF, 32'hDEADBEEE, 3'b010, 4'b1010, 1'b1);
    idle_cycles(2);
    // back-to-back: second start lands in the DONE cycle
    run_cmp(32'hAA000000, 32'h55FFFFFF, 3'b010, 4'b0000, 1'b0);
    run_cmp(32'h01020304, 32'h01020305, 3'b001, 4'b0000, 1'b0);
    idle_cycles(3);

    // reset after two beats discards the partial comparison and clears outputs
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.A = 8'h00;
    bus.B = 8'hFF;
    @(negedge clk);
    bus.A = 8'h00;
    bus.B = 8'hFF;
    @(negedge clk);
    reset        = 1'b1;
    bus.in_valid = 1'b1;
    @(negedge clk);
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    check("midrst_state", int'(dbg_state), 0);
    check("midrst_eq_gt_lt", int'({bus.EQ, bus.GT, bus.LT}), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_in_ready", int'(bus.in_ready), 0);
    run_cmp(32'hFFFFFFFF, 32'hFFFFFFFE, 3'b010, 4'b0000, 1'b0);
    idle_cycles(4);

    check("pending_results", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
